// File: rtl/floor_dispatch.sv
// Single-car floor dispatcher for a 7-floor shaft.
// Latches call buttons into a pending vector, runs a SCAN
// (elevator-algorithm) state machine, and tells the mover which floor
// to head for. A request clears only after the door has been open for
// DWELL un-overloaded cycles at that floor.
module floor_dispatch #(
    parameter int DWELL = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] call,
    input  logic [2:0] current,
    input  logic       door_open,
    input  logic       ovld,
    output logic [2:0] sel,
    output logic       direction,
    output logic [6:0] pending,
    output logic       serving
);

    localparam int CW = $clog2(DWELL + 2);
    // Count value on which the final qualifying dwell cycle is seen.
    // DWELL=0 gives 0, so the first qualifying cycle completes.
    localparam logic [CW-1:0] DWELL_LAST = (DWELL == 0) ? '0 : CW'(DWELL - 1);
    localparam logic [2:0] NO_DEST = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN,
        ST_DWELL
    } state_t;

    state_t          state_reg, state_next;
    logic [6:0]      pending_reg, pending_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            dir_reg, dir_next;

    // Floor-position masks relative to the car.
    logic [6:0] eq_mask, gt_mask, lt_mask, ge_mask, le_mask;
    logic [6:0] up_cand, down_cand, rem_pending, ahead, behind, clear_mask;
    logic [2:0] up_sel, down_sel;
    logic       cur_valid, here_pending, dwell_qualify, dwell_done;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_mask
            assign eq_mask[gi] = (current == 3'(gi));
            assign gt_mask[gi] = (current <  3'(gi));
            assign lt_mask[gi] = (current >  3'(gi));
            assign ge_mask[gi] = (current <= 3'(gi));
            assign le_mask[gi] = (current >= 3'(gi));
        end
    endgenerate

    assign cur_valid     = (current != NO_DEST);
    assign here_pending  = |(pending_reg & eq_mask);
    assign up_cand       = pending_reg & ge_mask;
    assign down_cand     = pending_reg & le_mask;
    assign dwell_qualify = (state_reg == ST_DWELL) && door_open && !ovld;
    assign dwell_done    = dwell_qualify && (cnt_reg >= DWELL_LAST);

    // Pending as it will look once this floor's request is retired.
    assign rem_pending = pending_reg & ~eq_mask;
    assign ahead  = dir_reg ? (rem_pending & lt_mask) : (rem_pending & gt_mask);
    assign behind = dir_reg ? (rem_pending & gt_mask) : (rem_pending & lt_mask);

    // Lowest pending floor at or above the car (UP target).
    always_comb begin
        up_sel = NO_DEST;
        for (int i = 6; i >= 0; i--) begin
            if (up_cand[i]) up_sel = 3'(i);
        end
    end

    // Highest pending floor at or below the car (DOWN target).
    always_comb begin
        down_sel = NO_DEST;
        for (int i = 0; i < 7; i++) begin
            if (down_cand[i]) down_sel = 3'(i);
        end
    end

    // Next-state, request bookkeeping and dwell counter.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        clear_mask   = '0;
        pending_next = pending_reg;
        if (cur_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (pending_reg == '0)          state_next = ST_IDLE;
                    else if (here_pending)          state_next = ST_DWELL;
                    else if (|(pending_reg & gt_mask)) state_next = ST_UP;
                    else                            state_next = ST_DOWN;
                end
                ST_UP: begin
                    if (up_sel == NO_DEST)                       state_next = ST_IDLE;
                    else if (current == up_sel && door_open)     state_next = ST_DWELL;
                end
                ST_DOWN: begin
                    if (down_sel == NO_DEST)                     state_next = ST_IDLE;
                    else if (current == down_sel && door_open)   state_next = ST_DWELL;
                end
                ST_DWELL: begin
                    if (dwell_done) begin
                        clear_mask = eq_mask;
                        if (ahead != '0)       state_next = dir_reg ? ST_DOWN : ST_UP;
                        else if (behind != '0) state_next = dir_reg ? ST_UP : ST_DOWN;
                        else                   state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
            // Clear beats a same-cycle call on the served floor.
            pending_next = (pending_reg | call) & ~clear_mask;
            // Counter runs only inside DWELL and restarts at 0 on each entry.
            if (state_reg != ST_DWELL || dwell_done) cnt_next = '0;
            else if (dwell_qualify)                  cnt_next = cnt_reg + 1'b1;
        end
    end

    // Direction remembers the last travel sense; held through IDLE/DWELL.
    always_comb begin
        dir_next = dir_reg;
        if (state_next == ST_UP)        dir_next = 1'b0;
        else if (state_next == ST_DOWN) dir_next = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pending_reg <= '0;
            cnt_reg     <= '0;
            dir_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
            dir_reg     <= dir_next;
        end
    end

    // Mover-facing outputs, combinational from state/pending/current.
    always_comb begin
        sel       = NO_DEST;
        direction = dir_reg;
        case (state_reg)
            ST_UP:    begin sel = up_sel;   direction = 1'b0; end
            ST_DOWN:  begin sel = down_sel; direction = 1'b1; end
            ST_DWELL: sel = current;
            default:  sel = NO_DEST;
        endcase
        if (!cur_valid) sel = NO_DEST;
    end

    assign pending = pending_reg;
    assign serving = (state_reg == ST_DWELL);

endmodule

// File: tb/tb_floor_dispatch.sv
// Directed testbench for floor_dispatch (DWELL=3 main instance,
// DWELL=0 companion instance sharing the same stimulus).
module tb_floor_dispatch;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] call;
    logic [2:0] current;
    logic       door_open;
    logic       ovld;
    logic [2:0] sel, sel0;
    logic       direction, direction0;
    logic [6:0] pending, pending0;
    logic       serving, serving0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    floor_dispatch #(.DWELL(3)) dut (
        .clk(clk), .reset(reset), .call(call), .current(current),
        .door_open(door_open), .ovld(ovld), .sel(sel),
        .direction(direction), .pending(pending), .serving(serving)
    );

    floor_dispatch #(.DWELL(0)) dut0 (
        .clk(clk), .reset(reset), .call(call), .current(current),
        .door_open(door_open), .ovld(ovld), .sel(sel0),
        .direction(direction0), .pending(pending0), .serving(serving0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; call = '0; current = 3'd0; door_open = 1'b0; ovld = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (pending !== 7'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected %b", pending, 7'b0); end
        n_checks++; if (sel !== 3'b111) begin n_fail++; $display("FAIL reset_sel: got %0d expected 7", sel); end
        n_checks++; if (serving !== 1'b0) begin n_fail++; $display("FAIL reset_serving: got %b expected 0", serving); end
        n_checks++; if (direction !== 1'b0) begin n_fail++; $display("FAIL reset_direction: got %b expected 0", direction); end
        $display("test_reset done");
    endtask

    task automatic test_single_call();
        do_reset();
        call = 7'b0100000;
        tick();
        call = '0;
        n_checks++; if (pending !== 7'b0100000) begin n_fail++; $display("FAIL single_pending: got %b expected %b", pending, 7'b0100000); end
        tick();
        n_checks++; if (sel !== 3'd5) begin n_fail++; $display("FAIL single_sel: got %0d expected 5", sel); end
        n_checks++; if (direction !== 1'b0) begin n_fail++; $display("FAIL single_dir: got %b expected 0", direction); end
        n_checks++; if (serving !== 1'b0) begin n_fail++; $display("FAIL single_serving: got %b expected 0", serving); end
        $display("test_single_call done");
    endtask

    task automatic test_scan();
        do_reset();
        current = 3'd2;
        call = 7'b0100000;
        tick();
        call = '0;
        tick();
        call = 7'b0010010;
        tick();
        call = '0;
        n_checks++; if (sel !== 3'd4) begin n_fail++; $display("FAIL scan_sel4: got %0d expected 4", sel); end
        current = 3'd4; door_open = 1'b1;
        tick();
        n_checks++; if (serving !== 1'b1) begin n_fail++; $display("FAIL scan_dwell4: got %b expected 1", serving); end
        tick(); tick();
        n_checks++; if (pending !== 7'b0110010) begin n_fail++; $display("FAIL scan_hold4: got %b expected %b", pending, 7'b0110010); end
        tick();
        door_open = 1'b0;
        n_checks++; if (pending !== 7'b0100010) begin n_fail++; $display("FAIL scan_clear4: got %b expected %b", pending, 7'b0100010); end
        n_checks++; if (sel !== 3'd5) begin n_fail++; $display("FAIL scan_sel5: got %0d expected 5", sel); end
        current = 3'd5; door_open = 1'b1;
        tick(); tick(); tick(); tick();
        door_open = 1'b0;
        n_checks++; if (pending !== 7'b0000010) begin n_fail++; $display("FAIL scan_clear5: got %b expected %b", pending, 7'b0000010); end
        n_checks++; if (sel !== 3'd1) begin n_fail++; $display("FAIL scan_sel1: got %0d expected 1", sel); end
        n_checks++; if (direction !== 1'b1) begin n_fail++; $display("FAIL scan_dir_down: got %b expected 1", direction); end
        // While going down, a call above must not move the target.
        call = 7'b1000000;
        tick();
        call = '0;
        n_checks++; if (sel !== 3'd1) begin n_fail++; $display("FAIL scan_down_ignore: got %0d expected 1", sel); end
        $display("test_scan done");
    endtask

    task automatic test_overload();
        do_reset();
        current = 3'd3; door_open = 1'b1; ovld = 1'b1;
        call = 7'b0001000;
        tick();
        call = '0;
        tick();
        n_checks++; if (serving !== 1'b1) begin n_fail++; $display("FAIL ovld_enter: got %b expected 1", serving); end
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (pending !== 7'b0001000) begin n_fail++; $display("FAIL ovld_hold: got %b expected %b", pending, 7'b0001000); end
        ovld = 1'b0;
        tick(); tick();
        n_checks++; if (pending !== 7'b0001000) begin n_fail++; $display("FAIL ovld_early: got %b expected %b", pending, 7'b0001000); end
        tick();
        n_checks++; if (pending !== 7'b0000000) begin n_fail++; $display("FAIL ovld_clear: got %b expected %b", pending, 7'b0); end
        n_checks++; if (serving !== 1'b0) begin n_fail++; $display("FAIL ovld_exit: got %b expected 0", serving); end
        $display("test_overload done");
    endtask

    task automatic test_call_held();
        do_reset();
        current = 3'd3; door_open = 1'b1;
        call = 7'b0001000;
        tick(); tick(); tick(); tick(); tick();
        n_checks++; if (pending !== 7'b0000000) begin n_fail++; $display("FAIL held_clear: got %b expected %b", pending, 7'b0); end
        tick();
        call = '0;
        n_checks++; if (pending !== 7'b0001000) begin n_fail++; $display("FAIL held_reset: got %b expected %b", pending, 7'b0001000); end
        $display("test_call_held done");
    endtask

    task automatic test_reset_mid_dwell();
        do_reset();
        current = 3'd0; door_open = 1'b1;
        call = 7'b1010101;
        tick();
        call = '0;
        tick(); tick();
        n_checks++; if (serving !== 1'b1) begin n_fail++; $display("FAIL mid_serving: got %b expected 1", serving); end
        reset = 1'b1;
        tick();
        n_checks++; if (pending !== 7'b0) begin n_fail++; $display("FAIL mid_pending: got %b expected %b", pending, 7'b0); end
        n_checks++; if (sel !== 3'b111) begin n_fail++; $display("FAIL mid_sel: got %0d expected 7", sel); end
        n_checks++; if (serving !== 1'b0) begin n_fail++; $display("FAIL mid_serving0: got %b expected 0", serving); end
        call = 7'b1111111;
        tick();
        n_checks++; if (pending !== 7'b0) begin n_fail++; $display("FAIL reset_vs_call: got %b expected %b", pending, 7'b0); end
        reset = 1'b0; call = '0; door_open = 1'b0;
        $display("test_reset_mid_dwell done");
    endtask

    task automatic test_all_floors();
        logic [6:0] exp_pend;
        do_reset();
        call = 7'b1111111;
        tick();
        call = '0;
        n_checks++; if (pending !== 7'b1111111) begin n_fail++; $display("FAIL all_latch: got %b expected %b", pending, 7'b1111111); end
        exp_pend = 7'b1111111;
        for (int f = 0; f < 7; f++) begin
            if (f > 0) begin
                n_checks++; if (sel !== 3'(f)) begin n_fail++; $display("FAIL all_sel_f%0d: got %0d expected %0d", f, sel, f); end
            end
            current = 3'(f); door_open = 1'b1;
            tick();
            n_checks++; if (serving !== 1'b1) begin n_fail++; $display("FAIL all_serve_f%0d: got %b expected 1", f, serving); end
            tick(); tick(); tick();
            door_open = 1'b0;
            exp_pend[f] = 1'b0;
            n_checks++; if (pending !== exp_pend) begin n_fail++; $display("FAIL all_pend_f%0d: got %b expected %b", f, pending, exp_pend); end
        end
        n_checks++; if (sel !== 3'b111) begin n_fail++; $display("FAIL all_idle_sel: got %0d expected 7", sel); end
        n_checks++; if (serving !== 1'b0) begin n_fail++; $display("FAIL all_idle_serving: got %b expected 0", serving); end
        $display("test_all_floors done");
    endtask

    task automatic test_invalid_floor();
        do_reset();
        call = 7'b0010000;
        tick();
        call = '0;
        tick();
        n_checks++; if (sel !== 3'd4) begin n_fail++; $display("FAIL inv_pre_sel: got %0d expected 4", sel); end
        current = 3'b111;
        call = 7'b0000010;
        tick();
        call = '0;
        n_checks++; if (pending !== 7'b0010000) begin n_fail++; $display("FAIL inv_pending: got %b expected %b", pending, 7'b0010000); end
        n_checks++; if (sel !== 3'b111) begin n_fail++; $display("FAIL inv_sel: got %0d expected 7", sel); end
        current = 3'd2;
        #1;
        n_checks++; if (sel !== 3'd4) begin n_fail++; $display("FAIL inv_resume_sel: got %0d expected 4", sel); end
        $display("test_invalid_floor done");
    endtask

    task automatic test_dwell_zero();
        do_reset();
        current = 3'd2; door_open = 1'b1;
        call = 7'b0000100;
        tick();
        call = '0;
        tick();
        n_checks++; if (serving0 !== 1'b1) begin n_fail++; $display("FAIL dw0_enter: got %b expected 1", serving0); end
        tick();
        n_checks++; if (pending0 !== 7'b0) begin n_fail++; $display("FAIL dw0_clear: got %b expected %b", pending0, 7'b0); end
        n_checks++; if (pending !== 7'b0000100) begin n_fail++; $display("FAIL dw3_still: got %b expected %b", pending, 7'b0000100); end
        door_open = 1'b0;
        $display("test_dwell_zero done");
    endtask

    initial begin
        reset = 1'b1; call = '0; current = '0; door_open = 1'b0; ovld = 1'b0;
        test_reset();
        test_single_call();
        test_scan();
        test_overload();
        test_call_held();
        test_reset_mid_dwell();
        test_all_floors();
        test_invalid_floor();
        test_dwell_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/floor_dispatch.md
FLOOR_DISPATCH -- requirements
Module: floor_dispatch

Interface
REQ-001 SHALL have parameter DWELL, default 3: door-open cycles needed at a served floor before its request clears.
REQ-002 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port call, input, 7: floor call buttons; bit i is floor i (0..6), level-sampled each cycle.
REQ-005 SHALL have port current, input, 3: car floor reported by the mover (0..6).
REQ-006 SHALL have port door_open, input, 1: high while either car door is open.
REQ-007 SHALL have port ovld, input, 1: car overloaded.
REQ-008 SHALL have port sel, output, 3: destination floor to the mover; 3'b111 = no destination.
REQ-009 SHALL have port direction, output, 1: 0 = up, 1 = down, to the mover.
REQ-010 SHALL have port pending, output, 7: registered outstanding-request vector.
REQ-011 SHALL have port serving, output, 1: high in state DWELL.

Function
REQ-012 SHALL set pending[i] on the clock edge after any cycle with call[i]=1.
REQ-013 SHALL clear pending[current] only on DWELL completion; clear wins over a same-cycle call on that floor.
REQ-014 SHALL implement states IDLE, UP, DOWN, DWELL.
REQ-015 IDLE: pending=0 -> stay; pending[current]=1 -> DWELL; else any pending above current -> UP; else DOWN.
REQ-016 UP: sel = lowest pending floor >= current; direction=0.
REQ-017 DOWN: sel = highest pending floor <= current; direction=1.
REQ-018 UP/DOWN -> DWELL when current==sel and door_open=1.
REQ-019 IDLE: sel=3'b111; direction holds last value. DWELL: sel=current; direction holds.
REQ-020 sel, direction, serving SHALL be combinational from state, pending, current; sel reflects a new call 1 cycle after call asserts.
REQ-021 DWELL counter SHALL clear on DWELL entry, increment each cycle door_open=1 and ovld=0, and hold while ovld=1 or door_open=0.
REQ-022 On counter reaching DWELL: clear pending[current]; next state = same direction if pending remains ahead, else opposite direction if pending behind, else IDLE.
REQ-023 "Ahead" for UP means floors > current; for DOWN means floors < current.
REQ-024 SCAN order: while UP, calls below current SHALL NOT change sel; while DOWN, calls above SHALL NOT change sel.
REQ-025 current=3'b111 (invalid): state, pending, and counter SHALL hold; sel=3'b111.
REQ-026 Calls on all floors simultaneously SHALL all latch in one cycle.
REQ-027 DWELL=0 SHALL complete on the first DWELL cycle with door_open=1 and ovld=0.

Reset
REQ-028 Reset SHALL force state=IDLE, pending=0, counter=0, direction=0, sel=3'b111, serving=0 on the next edge, aborting any in-progress UP/DOWN/DWELL.
REQ-029 Reset SHALL win over a simultaneous call.

Verification
REQ-030 Reset, current=0, call=7'b0100000 one cycle -> pending=7'b0100000, state UP, sel=5, direction=0.
REQ-031 Car at 2 going UP to 5, call[1] and call[4] -> sel=4 (floor 1 ignored); after floor-4 dwell sel=5; after floor-5 dwell DOWN, sel=1, direction=1.
REQ-032 current=sel=3, door_open=1, DWELL=3, ovld=1 for 5 cycles then 0 -> pending[3] clears exactly 3 cycles after ovld falls.
REQ-033 call[3] held high through DWELL completion at floor 3 -> pending[3]=0 on the completion edge, re-sets the following edge.
REQ-034 Reset asserted mid-DWELL with pending=7'b1010101 -> next cycle pending=0, sel=3'b111, serving=0.
REQ-035 call=7'b1111111 in one cycle with current=0 -> pending=7'b1111111; floors served in order 0,1,2,...,6, then IDLE.
